// File: rtl/gaosi_pkg.sv
// Shared constants and helpers for the 5x5 Gaussian row scheduler.
package gaosi_pkg;

    localparam int KSIZE  = 5;
    localparam int BORDER = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int win_bit(input int r, input int c);
        return KSIZE * r + c;
    endfunction

endpackage

// File: rtl/gaosi_row_ring.sv
// Five-row ring of 1-bit camera rows with a combinational 5x5 window tap.
module gaosi_row_ring
    import gaosi_pkg::*;
#(
    parameter int WIDTH = 320
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       we,
    input  logic [WIDTH-1:0]           row_in,
    input  logic [$clog2(WIDTH)-1:0]   col,
    output logic [KSIZE*KSIZE-1:0]     win
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rows [KSIZE];
    logic [2:0]       wr_ptr;
    logic [3:0]       slot;
    logic [CW-1:0]    base;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= 3'd0;
        end else if (we) begin
            wr_ptr <= (wr_ptr == 3'(KSIZE - 1)) ? 3'd0 : wr_ptr + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            rows[wr_ptr] <= row_in;
        end
    end

    assign base = col - CW'(BORDER);

    // wr_ptr names the oldest slot, so window row r lives at (wr_ptr + r) mod 5.
    always_comb begin
        win  = '0;
        slot = '0;
        for (int r = 0; r < KSIZE; r++) begin
            slot = {1'b0, wr_ptr} + 4'(r);
            if (slot >= 4'(KSIZE)) begin
                slot = slot - 4'(KSIZE);
            end
            win[win_bit(r, 0) +: KSIZE] = rows[slot[2:0]][base +: KSIZE];
        end
    end

endmodule

// File: rtl/gaosi_line_sched.sv
// Row scheduler: fills the ring, scans 5x5 windows to the filter and
// reassembles the filtered pixels into a published output line.
module gaosi_line_sched
    import gaosi_pkg::*;
#(
    parameter int WIDTH    = 320,
    parameter int FILT_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   frame_start,
    input  logic                   row_update,
    input  logic [WIDTH-1:0]       row_in,
    output logic                   win_valid,
    output logic [KSIZE*KSIZE-1:0] win_data,
    input  logic                   filt_out,
    output logic [WIDTH-1:0]       line_pixel,
    output logic                   start,
    output logic                   busy,
    output logic                   row_drop
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] COL_FIRST  = CW'(BORDER);
    localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1 - BORDER);
    localparam logic [3:0]    DRAIN_LAST = 4'(FILT_LAT - 1);
    localparam logic [2:0]    FILL_FULL  = 3'(KSIZE);

    state_t                 state, state_nxt;
    logic [2:0]             fill, fill_inc;
    logic [CW-1:0]          col;
    logic [3:0]             drain_cnt;
    logic                   accept, drain_end;
    logic [KSIZE*KSIZE-1:0] ring_win;
    logic                   vld_p [FILT_LAT];
    logic [CW-1:0]          col_p [FILT_LAT];
    logic [WIDTH-1:0]       out_line, out_line_nxt;

    function automatic logic [WIDTH-1:0] clear_border(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        r[BORDER-1:0]        = '0;
        r[WIDTH-1 -: BORDER] = '0;
        return r;
    endfunction

    assign accept    = (state == ST_IDLE) && row_update && en && !frame_start;
    assign fill_inc  = (fill == FILL_FULL) ? FILL_FULL : fill + 3'd1;
    assign drain_end = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

    gaosi_row_ring #(.WIDTH(WIDTH)) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clr    (frame_start),
        .we     (accept),
        .row_in (row_in),
        .col    (col),
        .win    (ring_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && fill_inc == FILL_FULL) state_nxt = ST_SCAN;
            ST_SCAN:  if (col == COL_LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (frame_start) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        win_valid = (state == ST_SCAN);
        win_data  = (state == ST_SCAN) ? ring_win : '0;
        busy      = (state != ST_IDLE);
        start     = (state == ST_DONE);
        row_drop  = (state != ST_IDLE) && row_update && !frame_start;
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            fill      <= 3'd0;
            col       <= COL_FIRST;
            drain_cnt <= 4'd0;
        end else begin
            if (accept) fill <= fill_inc;
            col       <= (state == ST_SCAN) ? col + CW'(1) : COL_FIRST;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
        end
    end

    // Filter latency stages: (vld_p, col_p) tag each filt_out with its column.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            for (int i = 0; i < FILT_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= win_valid;
            for (int i = 1; i < FILT_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        col_p[0] <= col;
        for (int i = 1; i < FILT_LAT; i++) col_p[i] <= col_p[i-1];
    end

    always_comb begin
        out_line_nxt = out_line;
        if (vld_p[FILT_LAT-1]) begin
            out_line_nxt[col_p[FILT_LAT-1]] = filt_out;
        end
    end

    always_ff @(posedge clk) begin
        out_line <= out_line_nxt;
    end

    // Loaded on the last DRAIN cycle so the new line is visible alongside start.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_pixel <= '0;
        end else if (drain_end && !frame_start) begin
            line_pixel <= clear_border(out_line_nxt);
        end
    end

endmodule

// File: tb/tb_gaosi_line_sched.sv
// Directed bench for gaosi_line_sched with a queue scoreboard on start.
module tb_gaosi_line_sched;

    localparam int W  = 320;
    localparam int FL = 2;

    logic          clk = 1'b0;
    logic          rst, en, frame_start, row_update, filt_out;
    logic [W-1:0]  row_in;
    logic          win_valid, start, busy, row_drop;
    logic [24:0]   win_data;
    logic [W-1:0]  line_pixel;

    gaosi_line_sched #(.WIDTH(W), .FILT_LAT(FL)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .frame_start (frame_start),
        .row_update  (row_update),
        .row_in      (row_in),
        .win_valid   (win_valid),
        .win_data    (win_data),
        .filt_out    (filt_out),
        .line_pixel  (line_pixel),
        .start       (start),
        .busy        (busy),
        .row_drop    (row_drop)
    );

    always #5 clk = ~clk;

    // Identity filter: centre tap of the window, FL cycles late.
    logic [FL-1:0] fd = '0;
    always @(posedge clk) fd <= {fd[0], win_data[12]};
    assign filt_out = fd[FL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0, winv_cnt = 0, drop_cnt = 0, t_row = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] hist  [$];
    logic [W-1:0] mon_exp, ones, aa, pp, qq, rr, last_exp;

    always @(negedge clk) begin
        if (win_valid) winv_cnt++;
        if (row_drop) drop_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && start) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start line_pixel=%0h required=no start", line_pixel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (line_pixel !== mon_exp) begin
                    errors++;
                    $display("FAIL line_pixel actual=%0h required=%0h", line_pixel, mon_exp);
                end
            end
        end
    end

    function automatic logic [W-1:0] edge0(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        r[1:0]     = 2'b00;
        r[W-1:W-2] = 2'b00;
        return r;
    endfunction

    function automatic logic [W-1:0] kpat(input int k);
        logic [W-1:0] v;
        v = '0;
        v[4:0]     = 5'(k);
        v[W-1 -: 5] = 5'(k);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int n);
        goto(n);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%0b required=0", busy);
        end
    endtask

    task automatic send_row(input logic [W-1:0] v, input bit track);
        @(posedge clk);
        #1;
        wait_idle();
        row_update = 1'b1;
        row_in     = v;
        t_row      = cyc;
        if (en) begin
            hist.push_back(v);
            if (hist.size() > 5) void'(hist.pop_front());
            if (hist.size() == 5 && track) exp_q.push_back(edge0(hist[2]));
        end
        @(posedge clk);
        #1;
        row_update = 1'b0;
    endtask

    task automatic pulse_frame_start();
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        hist.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_line_pixel"}, line_pixel, '0);
        chk({tag, "_win_valid"}, W'(win_valid), '0);
        chk({tag, "_win_data"}, W'(win_data), '0);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_start"}, W'(start), '0);
        chk({tag, "_row_drop"}, W'(row_drop), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w0, d0;
        ones = '1;
        for (int i = 0; i < W; i++) begin
            aa[i] = (i % 2 == 1);
            pp[i] = (i % 3 == 0);
            rr[i] = (i % 5 == 0);
        end
        qq = ~pp;
        rst = 1'b1; en = 1'b1; frame_start = 1'b0; row_update = 1'b0; row_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Fill and timing, centre row carries the alternating pattern.
        w0 = winv_cnt;
        send_row(ones, 1'b1);
        send_row(ones, 1'b1);
        send_row(aa, 1'b1);
        send_row(ones, 1'b1);
        sample(cyc + 2);
        chk("fill4_no_window", W'(winv_cnt - w0), '0);
        send_row(ones, 1'b1);
        t = t_row;
        sample(t + 1);
        chk("first_win_valid", W'(win_valid), W'(1));
        chk("first_win_data", W'(win_data), W'({5'h1F, 5'h1F, 5'h0A, 5'h1F, 5'h1F}));
        sample(t + 316);
        chk("last_win_valid", W'(win_valid), W'(1));
        sample(t + 317);
        chk("drain_win_valid", W'(win_valid), '0);
        sample(t + 318);
        chk("start_early", W'(start), '0);
        sample(t + 319);
        chk("start_on_time", W'(start), W'(1));
        chk("busy_in_done", W'(busy), W'(1));
        sample(t + 320);
        chk("busy_after_done", W'(busy), '0);
        chk("start_one_cycle", W'(start), '0);
        chk("window_count", W'(winv_cnt - w0), W'(316));

        // Overflow during scan.
        d0 = drop_cnt;
        send_row(pp, 1'b1);
        t = t_row;
        goto(t + 100);
        row_update = 1'b1;
        row_in     = qq;
        @(negedge clk);
        chk("row_drop_pulse", W'(row_drop), W'(1));
        @(posedge clk);
        #1;
        row_update = 1'b0;
        sample(t + 101);
        chk("row_drop_cleared", W'(row_drop), '0);
        chk("row_drop_count", W'(drop_cnt - d0), W'(1));
        send_row(rr, 1'b1);
        wait_idle();

        // Ring wrap with rows k = 1..7.
        pulse_frame_start();
        for (int k = 1; k <= 7; k++) send_row(kpat(k), 1'b1);
        t = t_row;
        sample(t + 1);
        chk("wrap_win_col2", W'(win_data), W'({5'd7, 5'd6, 5'd5, 5'd4, 5'd3}));
        sample(t + 316);
        chk("wrap_win_col317", W'(win_data), W'({5'd7, 5'd6, 5'd5, 5'd4, 5'd3}));
        wait_idle();
        last_exp = edge0(kpat(5));

        // Abort mid-scan.
        send_row(kpat(8), 1'b0);
        t = t_row;
        goto(t + 50);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        hist.delete();
        sample(t + 51);
        chk("abort_win_valid", W'(win_valid), '0);
        chk("abort_busy", W'(busy), '0);
        sample(t + 330);
        chk("abort_line_held", line_pixel, last_exp);
        w0 = winv_cnt;
        for (int k = 9; k <= 12; k++) send_row(kpat(k), 1'b1);
        sample(cyc + 2);
        chk("abort_refill_no_window", W'(winv_cnt - w0), '0);
        send_row(kpat(13), 1'b1);
        wait_idle();

        // Reset mid-scan, then rows ignored while disabled.
        send_row(kpat(14), 1'b0);
        t = t_row;
        goto(t + 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        sample(t + 201);
        check_idle_outputs("rst_mid_scan");
        en = 1'b0;
        w0 = winv_cnt;
        d0 = drop_cnt;
        for (int k = 0; k < 5; k++) send_row(ones, 1'b1);
        sample(cyc + 3);
        chk("en0_no_window", W'(winv_cnt - w0), '0);
        chk("en0_no_drop", W'(drop_cnt - d0), '0);
        chk("en0_not_busy", W'(busy), '0);
        en = 1'b1;
        for (int k = 15; k <= 18; k++) send_row(kpat(k), 1'b1);
        sample(cyc + 2);
        chk("en1_refill_no_window", W'(winv_cnt - w0), '0);
        send_row(kpat(19), 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gaosi_line_sched.md
Name: gaosi_line_sched

Overview:
- Row scheduler for the 5x5 Gaussian filter stage of the OV5640 binarised-pixel pipeline.
- Buffers the last 5 camera rows of WIDTH 1-bit pixels in a ring.
- Once 5 rows are valid, streams one 5x5 window per cycle to the filter and reassembles the filter's 1-bit results into an output line.
- Publishes the line with a one-cycle start pulse to the downstream consumer.

Parameters:
- WIDTH, 320, pixels per row. Must be at least 8.
- FILT_LAT, 2, cycles from win_valid/win_data to the matching filt_out. Range 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  accept enable. While low in IDLE, row_update is ignored.
- frame_start  in  1  pulse that clears the row fill count and aborts any scan in progress.
- row_update  in  1  one-cycle pulse qualifying row_in.
- row_in  in  WIDTH  new row, bit i = column i.
- win_valid  out  1  window valid to the filter (drives the filter's en).
- win_data  out  25  5x5 window, bit 5*r+c = row r (0 oldest), column col-2+c.
- filt_out  in  1  filter result, FILT_LAT cycles after its window.
- line_pixel  out  WIDTH  last completed filtered line.
- start  out  1  one-cycle pulse, line_pixel updated.
- busy  out  1  high in SCAN, DRAIN and DONE.
- row_drop  out  1  one-cycle pulse when a row was rejected.

Behaviour:
- Reset values: line_pixel=0, start=0, win_valid=0, win_data=0, busy=0, row_drop=0, fill=0, state=IDLE, ring contents don't-care.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE
  - If row_update && en: write row_in into the ring at wr_ptr, wr_ptr wraps 4->0, fill=min(fill+1,5).
  - If the post-write fill==5: go to SCAN next cycle with col=2.
  - Otherwise stay in IDLE.
- SCAN
  - win_valid=1; win_data is built from the current col.
  - col increments 2..WIDTH-3 (316 cycles for WIDTH=320).
  - After col==WIDTH-3: go to DRAIN.
- DRAIN
  - Hold for FILT_LAT cycles with win_valid=0, then go to DONE.
- Result capture
  - Delay line of FILT_LAT stages carries (valid, col).
  - When a delayed entry is valid, out_line[col]=filt_out.
  - out_line bits [1:0] and [WIDTH-1:WIDTH-2] are forced 0.
- DONE
  - line_pixel<=out_line and start=1, both in this single cycle.
  - Return to IDLE next cycle.
- Latency: with the 5th row accepted at cycle T, the first window is at T+1 and start is at T+(WIDTH-4)+FILT_LAT+1 (T+319 at defaults).
- Steady state: each later accepted row triggers one full scan, because fill stays 5 and the oldest row is overwritten.
- row_update while busy: row is not written, row_drop=1 that cycle, ring/fill/wr_ptr unchanged.
- row_update while en=0 in IDLE: ignored, no row_drop.
- en deasserted mid-scan: the scan completes normally.
- frame_start has priority over row_update in the same cycle:
  - fill=0, wr_ptr=0, state=IDLE, win_valid=0 next cycle;
  - the delay line is flushed; no start is issued for an aborted scan;
  - line_pixel holds its previous value.
- rst mid-scan: all outputs take their reset values next cycle.
- Window row order: r=0 is the ring slot at wr_ptr (oldest), r=4 is the newest, modulo 5.

Decomposition:
- Package gaosi_pkg holds:
  - KSIZE=5 and BORDER=2;
  - the state encoding localparams;
  - the function win_bit(r,c)=5*r+c.
- One sub-module, gaosi_row_ring, contains:
  - the 5xWIDTH storage, wr_ptr and write port;
  - a combinational 25-bit window extractor indexed by col and the oldest-slot pointer.
- gaosi_line_sched keeps the FSM, column counter, latency delay line and output register.

Test Plan:
- Fill: 4 rows of all-ones -> win_valid never rises. 5th row at cycle T -> win_valid high T+1..T+316, start exactly at T+319, busy low at T+320.
- Identity: drive filt_out = delayed win_data[12] with row 2 = 0xAAAA…A -> line_pixel[317:2] equals row 2 bits [317:2], bits [1:0] and [319:318] equal 0.
- Overflow: row_update at T+100 during scan -> row_drop pulse at T+100; the following scan uses the unchanged ring; start count stays 1.
- Ring wrap: rows with row_in = k for k=1..7 -> the window after row 7 has row 0 = row 3, row 4 = row 7; win_data bit order checked at col 2 and col 317.
- Abort: frame_start at T+50 -> win_valid=0 at T+51, no start, line_pixel unchanged; the next 4 rows produce no scan, the 5th row scans.
- Reset/enable: rst at T+200 -> all outputs 0 at T+201. With en=0 in IDLE, 5 row_updates -> no fill, no row_drop.
